// File: rtl/flop_add_pipe_if.sv
// Operand/result handshake bundle for flop_add_pipe.
// slave = adder side, master = operand source and result consumer.
interface flop_add_pipe_if #(
    parameter int W = 13
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] one;
    logic [W-1:0] other;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         ovf;
    logic         unf;

    modport master (
        output in_valid, one, other, sub, out_ready,
        input  in_ready, out_valid, result, ovf, unf
    );

    modport slave (
        input  in_valid, one, other, sub, out_ready,
        output in_ready, out_valid, result, ovf, unf
    );
endinterface

// File: rtl/flop_add_pipe.sv
// 3-stage small-float add/sub: unpack+align, mantissa add, normalise+round+pack.
// FLOP_ROUND_NEAREST_EN selects round-to-nearest-even; default truncates.
module flop_add_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    flop_add_pipe_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 1;
    localparam int AW = MW + 3;
    localparam int SW = AW + 1;
    localparam int EW = EXP_W + 2;
    localparam int SH = MW + 2;
    localparam logic [EXP_W-1:0] EMAX = '1;
`ifdef FLOP_ROUND_NEAREST_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    typedef struct packed {
        logic             sgn;
        logic [EXP_W-1:0] exp;
        logic [MW-1:0]    man;
        logic [AW-1:0]    aln;
        logic             eff_sub;
    } s1_t;

    typedef struct packed {
        logic             sgn;
        logic [EXP_W-1:0] exp;
        logic [SW-1:0]    sum;
    } s2_t;

    logic v1_q, v2_q, v3_q;
    logic v1_d, v2_d, v3_d;
    logic en1, en2, en3;
    logic ld1, ld2, ld3;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    logic [W-1:0] res_d, res_q;
    logic ovf_d, ovf_q, unf_d, unf_q;

    // a stage may load when the one after it is empty or draining
    assign en3 = !v3_q || bus.out_ready;
    assign en2 = !v2_q || en3;
    assign en1 = !v1_q || en2;
    assign ld1 = en1 && bus.in_valid;
    assign ld2 = en2 && v1_q;
    assign ld3 = en3 && v2_q;

    assign bus.in_ready  = en1;
    assign bus.out_valid = v3_q;
    assign bus.result    = res_q;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;

    always_comb begin
        v1_d = en1 ? bus.in_valid : v1_q;
        v2_d = en2 ? v1_q : v2_q;
        v3_d = en3 ? v2_q : v3_q;
    end

    logic             sa, sb, a_big;
    logic [EXP_W-1:0] ea, eb, dexp;
    logic [MW-1:0]    ma, mb, msm;
    logic [2*SH-1:0]  wide;

    always_comb begin
        sa    = bus.one[W-1];
        ea    = bus.one[W-2:MAN_W];
        ma    = (ea == '0) ? '0 : {1'b1, bus.one[MAN_W-1:0]};
        sb    = bus.other[W-1] ^ bus.sub;
        eb    = bus.other[W-2:MAN_W];
        mb    = (eb == '0) ? '0 : {1'b1, bus.other[MAN_W-1:0]};
        a_big = {ea, ma} >= {eb, mb};
        s1_d.sgn     = a_big ? sa : sb;
        s1_d.exp     = a_big ? ea : eb;
        s1_d.man     = a_big ? ma : mb;
        s1_d.eff_sub = sa ^ sb;
        msm  = a_big ? mb : ma;
        dexp = a_big ? ea - eb : eb - ea;
        wide = '0;
        if (32'(dexp) >= SH) begin
            s1_d.aln = {{(AW-1){1'b0}}, |msm};
        end else begin
            wide     = {msm, 2'b00, {SH{1'b0}}} >> dexp;
            s1_d.aln = {wide[2*SH-1:SH], |wide[SH-1:0]};
        end
    end

    logic [SW-1:0] bx, sx;

    always_comb begin
        bx       = {1'b0, s1_q.man, 3'b000};
        sx       = {1'b0, s1_q.aln};
        s2_d.sgn = s1_q.sgn;
        s2_d.exp = s1_q.exp;
        s2_d.sum = s1_q.eff_sub ? bx - sx : bx + sx;
    end

    logic [AW-1:0]          nv;
    logic signed [EW-1:0]   ne, fe;
    logic [MAN_W-1:0]       frac;
    logic                   inc, rc;
    int                     lz;

    always_comb begin
        lz = 0;
        for (int i = 0; i < AW; i++) begin
            if (s2_q.sum[i]) lz = AW - 1 - i;
        end
        if (s2_q.sum[SW-1]) begin
            nv = {s2_q.sum[SW-1:2], |s2_q.sum[1:0]};
            ne = {2'b00, s2_q.exp} + EW'(1);
        end else begin
            nv = s2_q.sum[AW-1:0] << lz;
            ne = {2'b00, s2_q.exp} - EW'(lz);
        end
        // nv = hidden | mantissa | guard | round | sticky
        inc  = RNE & nv[2] & (nv[1] | nv[0] | nv[3]);
        rc   = inc & (&nv[AW-2:3]);
        frac = nv[AW-2:3] + MAN_W'(inc);
        fe   = ne + EW'(rc);
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (!nv[AW-1]) begin
            res_d = '0;
        end else if (fe > $signed({2'b00, EMAX})) begin
            res_d = {s2_q.sgn, {(W-1){1'b1}}};
            ovf_d = 1'b1;
        end else if (fe[EW-1] || fe == '0) begin
            res_d = {s2_q.sgn, {(W-1){1'b0}}};
            unf_d = 1'b1;
        end else begin
            res_d = {s2_q.sgn, fe[EXP_W-1:0], frac};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            s1_q  <= '0;
            s2_q  <= '0;
            res_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            if (ld1) s1_q <= s1_d;
            if (ld2) s2_q <= s2_d;
            if (ld3) begin
                res_q <= res_d;
                ovf_q <= ovf_d;
                unf_q <= unf_d;
            end
        end
    end
endmodule

// File: tb/tb_flop_add_pipe.sv
// Bench for flop_add_pipe: exact-integer reference model, scoreboard,
// directed corner cases, backpressure, random traffic and async reset.
module tb_flop_add_pipe;
    localparam int EXP_W = 5;
    localparam int MAN_W = 7;
    localparam int W     = 1 + EXP_W + MAN_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    logic [W+1:0] exp_q[$];

    always #5 clk = ~clk;

    flop_add_pipe_if #(.W(W)) bus ();

    flop_add_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, req);
    endtask

    // Exact value: operand = M * 2^(e-1) in units of the smallest exponent.
    function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic s);
        longint va, vb, sum, mag, top;
        int ea, eb, p, e, sh;
        logic sg, ov, un;
        logic [W-1:0] r;
        ea = int'(a[W-2:MAN_W]);
        eb = int'(b[W-2:MAN_W]);
        va = 0;
        vb = 0;
        if (ea != 0)
            va = ((longint'(1) << MAN_W) + longint'(a[MAN_W-1:0])) << (ea - 1);
        if (eb != 0)
            vb = ((longint'(1) << MAN_W) + longint'(b[MAN_W-1:0])) << (eb - 1);
        if (a[W-1]) va = -va;
        if (b[W-1] ^ s) vb = -vb;
        sum = va + vb;
        if (sum == 0) return '0;
        sg  = (sum < 0);
        mag = sg ? -sum : sum;
        p = 0;
        for (int i = 0; i < 62; i++) if ((mag >> i) != 0) p = i;
        e = p - MAN_W + 1;
        if (p >= MAN_W) begin
            sh  = p - MAN_W;
            top = mag >> sh;
`ifdef FLOP_ROUND_NEAREST_EN
            if (sh > 0) begin
                longint rem, half;
                rem  = mag - (top << sh);
                half = longint'(1) << (sh - 1);
                if (rem > half || (rem == half && (top % 2) == 1)) top++;
                if (top == (longint'(1) << (MAN_W + 1))) begin
                    top = top >> 1;
                    e++;
                end
            end
`endif
        end else begin
            top = mag << (MAN_W - p);
        end
        ov = 1'b0;
        un = 1'b0;
        if (e > (1 << EXP_W) - 1) begin
            r  = {sg, {(W-1){1'b1}}};
            ov = 1'b1;
        end else if (e <= 0) begin
            r  = {sg, {(W-1){1'b0}}};
            un = 1'b1;
        end else begin
            r = {sg, EXP_W'(e), MAN_W'(top)};
        end
        return {ov, un, r};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready && exp_q.size() > 0)
                void'(exp_q.pop_front());
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.one, bus.other, bus.sub));
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                chk("stale_out", 32'(bus.out_valid), 32'd0);
            end else begin
                chk("sb_result", 32'(bus.result), 32'(exp_q[0][W-1:0]));
                chk("sb_ovf", 32'(bus.ovf), 32'(exp_q[0][W+1]));
                chk("sb_unf", 32'(bus.unf), 32'(exp_q[0][W]));
            end
        end
    end

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] w;
        w = W'($urandom);
        case ($urandom_range(0, 7))
            0: w[W-2:MAN_W] = '0;
            1: w[W-2:MAN_W] = '1;
            default: ;
        endcase
        return w;
    endfunction

    task automatic set_rnd();
        logic [W-1:0] a, b;
        a = rnd_word();
        b = rnd_word();
        case ($urandom_range(0, 3))
            0: b = a;
            1: b[W-2:MAN_W] = a[W-2:MAN_W] + EXP_W'($urandom_range(0, 2));
            default: ;
        endcase
        bus.one   = a;
        bus.other = b;
        bus.sub   = 1'($urandom_range(0, 1));
    endtask

    task automatic dir(input string name, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] er, input logic eo,
                       input logic eu);
        int lat;
        chk({name, "_model"}, 32'(model(a, b, s)), 32'({eo, eu, er}));
        bus.one       = a;
        bus.other     = b;
        bus.sub       = s;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 10 && !bus.in_ready; k++) @(negedge clk);
        chk({name, "_rdy"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_lat"}, 32'(lat), 32'd3);
        chk({name, "_res"}, 32'(bus.result), 32'(er));
        chk({name, "_ovf"}, 32'(bus.ovf), 32'(eo));
        chk({name, "_unf"}, 32'(bus.unf), 32'(eu));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] rnd_exp;
        int acc, nout, pend;
        bus.in_valid  = 1'b0;
        bus.one       = '0;
        bus.other     = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_unf", 32'(bus.unf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        dir("ref", 13'b1101000000001, 13'b0100100100010, 1'b0,
            13'b1100110110001, 1'b0, 1'b0);
        dir("one_plus_one", 13'b0011110000000, 13'b0011110000000, 1'b0,
            13'b0100000000000, 1'b0, 1'b0);
        dir("one_minus_one", 13'b0011110000000, 13'b0011110000000, 1'b1,
            13'b0000000000000, 1'b0, 1'b0);
`ifdef FLOP_ROUND_NEAREST_EN
        rnd_exp = 13'b0011110000001;
`else
        rnd_exp = 13'b0011110000000;
`endif
        dir("round", 13'b0011110000000, 13'b0001111000000, 1'b0,
            rnd_exp, 1'b0, 1'b0);
        dir("ovf_pos", 13'b0111111111111, 13'b0111111111111, 1'b0,
            13'b0111111111111, 1'b1, 1'b0);
        dir("ovf_neg", 13'b1111111111111, 13'b1111111111111, 1'b0,
            13'b1111111111111, 1'b1, 1'b0);
        dir("zero_pass", 13'b0000000000000, 13'b0100100100010, 1'b1,
            13'b1100100100010, 1'b0, 1'b0);
        dir("zero_zero", 13'b0000000000000, 13'b1000000000000, 1'b0,
            13'b0000000000000, 1'b0, 1'b0);
        dir("unf_pos", 13'b0000011000000, 13'b0000010000000, 1'b1,
            13'b0000000000000, 1'b0, 1'b1);
        dir("unf_neg", 13'b0000010000000, 13'b0000011000000, 1'b1,
            13'b1000000000000, 1'b0, 1'b1);

        // backpressure: 5 ops against a stalled consumer
        bus.out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.in_valid == 1'b0 || acc > 0) set_rnd();
            bus.in_valid = (acc < 5);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) acc++;
            @(posedge clk);
            #1;
        end
        chk("bp_accepted", 32'(acc), 32'd3);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        nout = 0;
        for (int c = 0; c < 5; c++) begin
            if (acc < 5) set_rnd();
            bus.in_valid = (acc < 5);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) acc++;
            if (bus.out_valid && bus.out_ready) nout++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("bp_all_accepted", 32'(acc), 32'd5);
        chk("bp_back_to_back", 32'(nout), 32'd5);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // random traffic with random backpressure
        pend = 0;
        for (int c = 0; c < 1500; c++) begin
            if (pend == 0 && $urandom_range(0, 3) != 0) begin
                set_rnd();
                pend = 1;
            end
            bus.in_valid  = (pend != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) pend = 0;
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && (exp_q.size() != 0 || bus.out_valid); c++) begin
            @(posedge clk);
            #1;
        end
        chk("rand_drained", 32'(exp_q.size()), 32'd0);

        // async reset with two ops in flight
        bus.out_ready = 1'b0;
        bus.one       = 13'b0111111111111;
        bus.other     = 13'b0111111111111;
        bus.sub       = 1'b0;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.one   = 13'b1101000000001;
        bus.other = 13'b0100100100010;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        #1 chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        chk("pre_rst_ovf", 32'(bus.ovf), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_result", 32'(bus.result), 32'd0);
        chk("mid_rst_ovf", 32'(bus.ovf), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1 chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        nout = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.out_valid) nout++;
            @(posedge clk);
            #1;
        end
        chk("post_rst_no_stale", 32'(nout), 32'd0);
        dir("post_rst_ref", 13'b1101000000001, 13'b0100100100010, 1'b0,
            13'b1100110110001, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
